// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: D = A - B, one bit per clock, LSB first.
// Operands arrive on a valid/ready handshake; the result leaves on a second one.
module serial_ripple_subtractor #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] D,
    output logic         Bout
);

    localparam int unsigned CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    a_sr;
    logic [W-1:0]    b_sr;
    logic [W-1:0]    diff_sr;
    logic            br;
    logic [CW-1:0]   cnt;

    logic            a_bit;
    logic            b_bit;
    logic            d_bit;
    logic            br_nxt;
    logic            last_bit;
    logic [W-1:0]    diff_nxt;

    // One full-subtractor bit step on the current LSBs, plus the shifted working difference
    always_comb begin
        a_bit    = a_sr[0];
        b_bit    = b_sr[0];
        d_bit    = a_bit ^ b_bit ^ br;
        br_nxt   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
        diff_nxt = diff_sr >> 1;
        diff_nxt[W-1] = d_bit;
        last_bit = (cnt == CW'(W - 1));
    end

    // Control FSM and datapath registers; in_ready mirrors state == IDLE as a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            D         <= '0;
            Bout      <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            diff_sr   <= '0;
            br        <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr     <= A;
                        b_sr     <= B;
                        diff_sr  <= '0;
                        br       <= 1'b0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    diff_sr <= diff_nxt;
                    br      <= br_nxt;
                    cnt     <= cnt + CW'(1);
                    if (last_bit) begin
                        D         <= diff_nxt;
                        Bout      <= br_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor (W = 4).
module tb_serial_ripple_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] D;
    logic         Bout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_ripple_subtractor #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bo;
    } vec_t;

    vec_t vecs[5];

    // Reference: plain integer subtraction, wrapped modulo 2^W
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int diff;
        int wrapped;
        diff    = int'(a) - int'(b);
        wrapped = (diff + (1 << W)) % (1 << W);
        return {(diff < 0) ? 1'b1 : 1'b0, W'(wrapped)};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Present operands and wait (bounded) for acceptance; returns the acceptance cycle
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, output int t_acc);
        int n;
        n = 0;
        in_valid = 1'b1;
        A = a;
        B = b;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("accept_timeout", n, 0);
        @(posedge clk);
        t_acc = cyc;
        #1;
        in_valid = 1'b0;
        chk("in_ready_after_accept", int'(in_ready), 0);
    endtask

    // Wait for the result, scrambling A/B meanwhile, check it, then hold back-pressure for dly cycles
    task automatic get_result(input logic [W-1:0] a, input logic [W-1:0] b, input int dly,
                              input bit pend, input logic [W-1:0] pa, input logic [W-1:0] pb);
        int k;
        logic [W:0] m;
        m = model(a, b);
        k = 0;
        do begin
            A = W'($urandom);
            B = W'($urandom);
            @(posedge clk);
            #1;
            k++;
        end while (!out_valid && k < 20);
        chk("latency", k, W);
        chk("D", int'(D), int'(m[W-1:0]));
        chk("Bout", int'(Bout), int'(m[W]));
        if (dly > 0) begin
            out_ready = 1'b0;
            if (pend) begin
                in_valid = 1'b1;
                A = pa;
                B = pb;
            end
            for (int i = 0; i < dly; i++) begin
                @(posedge clk);
                #1;
                chk("bp_out_valid", int'(out_valid), 1);
                chk("bp_in_ready", int'(in_ready), 0);
                chk("bp_D", int'(D), int'(m[W-1:0]));
                chk("bp_Bout", int'(Bout), int'(m[W]));
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("out_valid_drop", int'(out_valid), 0);
        chk("in_ready_back", int'(in_ready), 1);
    endtask

    initial begin
        int t_acc;
        int t_prev;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0] = '{a: 4'h3, b: 4'h2, d: 4'h1, bo: 1'b0};
        vecs[1] = '{a: 4'h2, b: 4'h3, d: 4'hF, bo: 1'b1};
        vecs[2] = '{a: 4'h0, b: 4'hF, d: 4'h1, bo: 1'b1};
        vecs[3] = '{a: 4'hF, b: 4'h0, d: 4'hF, bo: 1'b0};
        vecs[4] = '{a: 4'hA, b: 4'hA, d: 4'h0, bo: 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_D", int'(D), 0);
        chk("rst_Bout", int'(Bout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table against hand-computed constants
        foreach (vecs[i]) begin
            accept(vecs[i].a, vecs[i].b, t_acc);
            get_result(vecs[i].a, vecs[i].b, 0, 1'b0, '0, '0);
            chk("vec_D", int'(D), int'(vecs[i].d));
            chk("vec_Bout", int'(Bout), int'(vecs[i].bo));
        end

        // Exhaustive sweep, checking back-to-back spacing of acceptances
        t_prev = -1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                accept(W'(a), W'(b), t_acc);
                if (t_prev >= 0) chk("accept_spacing", t_acc - t_prev, W + 2);
                t_prev = t_acc;
                get_result(W'(a), W'(b), 0, 1'b0, '0, '0);
            end
        end

        // Random operands with random back-pressure
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            accept(ra, rb, t_acc);
            get_result(ra, rb, int'($urandom_range(0, 3)), 1'b0, '0, '0);
        end

        // Back-pressure with pending operands held on the input
        accept(4'h9, 4'h4, t_acc);
        get_result(4'h9, 4'h4, 5, 1'b1, 4'h1, 4'h6);
        chk("pending_in_valid_held", int'(in_valid), 1);
        accept(4'h1, 4'h6, t_acc);
        get_result(4'h1, 4'h6, 0, 1'b0, '0, '0);
        chk("pending_D", int'(D), 4'hB);
        chk("pending_Bout", int'(Bout), 1);

        // Operand change after capture (get_result scrambles A/B during RUN)
        accept(4'h5, 4'h1, t_acc);
        get_result(4'h5, 4'h1, 0, 1'b0, '0, '0);
        chk("scramble_D", int'(D), 4'h4);
        chk("scramble_Bout", int'(Bout), 0);

        // Reset during bit 2 of RUN after a nonzero result with borrow
        accept(4'h2, 4'h5, t_acc);
        get_result(4'h2, 4'h5, 0, 1'b0, '0, '0);
        accept(4'hC, 4'h3, t_acc);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_out_valid", int'(out_valid), 0);
        chk("midrun_rst_D", int'(D), 0);
        chk("midrun_rst_Bout", int'(Bout), 0);
        chk("midrun_rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk);
            #1;
        end
        chk("aborted_no_result", int'(out_valid), 0);
        accept(4'h7, 4'h9, t_acc);
        get_result(4'h7, 4'h9, 0, 1'b0, '0, '0);
        chk("post_rst_D", int'(D), 4'hE);
        chk("post_rst_Bout", int'(Bout), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
